csr_bank_apb: RTL and testbench
===============================

Name: csr_bank_apb

Overview:
Parametrised APB-slave CSR bank; next generation of the ALU command/result register set.
- Holds NUM_OPERANDS operand registers and one command register.
- Snapshots a command word into a one-deep pending slot and pushes it to FIFO_IN with a full-aware handshake.
- Fetches results from FIFO_OUT into a sticky RESULT register, cleared on read.
- Adds APB readback, error response and a dropped-command counter.

Parameters:
APB_BUS_SIZE, 32, APB data width
ADDR_WIDTH, 8, APB byte address width
DATA_SIZE, 16, operand width taken from each DATA register's LSBs
NUM_OPERANDS, 2, number of DATA registers (1..8)
ID_SIZE, 8, command id width (ID_SIZE <= 8)
OPERATION_SIZE, 2, opcode width (OPERATION_SIZE <= 7)
FIFO_OUT_WIDTH, 25, result width (<= APB_BUS_SIZE)
FIFO_IN_WIDTH, NUM_OPERANDS*DATA_SIZE+ID_SIZE+OPERATION_SIZE, command word width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  ADDR_WIDTH  APB byte address
pwdata  in  APB_BUS_SIZE  APB write data
prdata  out  APB_BUS_SIZE  APB read data
pready  out  1  APB ready, tied 1
pslverr  out  1  APB error
fifo_in_full  in  1  FIFO_IN full
fifo_in_w_en  out  1  FIFO_IN push strobe
fifo_in_wdata  out  FIFO_IN_WIDTH  command word
fifo_out_empty  in  1  FIFO_OUT empty
fifo_out_r_en  out  1  FIFO_OUT pop strobe
fifo_out_rdata  in  FIFO_OUT_WIDTH  FIFO_OUT data, valid one cycle after r_en
irq  out  1  result interrupt (CSR_IRQ_EN only)

Behaviour:
- Reset: all registers 0.
  - Outputs fifo_in_w_en, fifo_out_r_en, prdata, pslverr and irq are 0.
  - Result FSM goes to R_IDLE.
- APB: zero wait state.
  - Accesses complete when psel&penable.
  - Writes commit at that clock edge.
  - prdata is combinational from registers while psel&penable, else 0.
- Address map, word offsets:
  - 0x00 CTRL RW: bit0 START, write-1, reads 0; [OPERATION_SIZE:1] OP; [8+:ID_SIZE] ID; bit31 IRQ_MASK.
  - 0x04 STATUS RO: bit0 fifo_in_full, bit1 fifo_out_empty, bit2 pending, bit3 res_valid, [15:8] drop_cnt.
  - 0x08 RESULT RO: zero-extended result; a read clears res_valid.
  - 0x0C DROP_CLR WO: any write zeroes drop_cnt.
  - 0x10+4*i DATA_i RW, for i < NUM_OPERANDS.
- pslverr=1 for the completing cycle on:
  - an unmapped address;
  - a write to STATUS or RESULT;
  - a read of DROP_CLR.
  - Such writes have no effect; error reads return 0.
- Start:
  - A CTRL write with pwdata[0]=1 and pending=0 does two things at that edge:
    - snapshots {DATA_{N-1}[DATA_SIZE-1:0], ..., DATA_0[DATA_SIZE-1:0], ID, OP} into the pending slot, using the register values before the write and the OP/ID being written;
    - sets pending=1.
  - START with pending=1: command dropped, drop_cnt+1, saturating at 255. OP and ID still update.
- Push:
  - fifo_in_w_en = pending & !fifo_in_full, registered-free.
  - fifo_in_wdata = pending slot.
  - pending clears on the edge where w_en=1.
  - Earliest push is the cycle after the START write.
  - A START accepted in the same cycle as a push is treated as pending=1, i.e. dropped.
- Result FSM:
  - R_IDLE: if !fifo_out_empty & !res_valid, assert fifo_out_r_en for 1 cycle, go to R_FETCH.
  - R_FETCH: capture fifo_out_rdata into RESULT, set res_valid, go to R_HOLD.
  - R_HOLD: wait for a RESULT read; res_valid clears, go to R_IDLE.
  - A RESULT read in R_IDLE/R_FETCH returns the current register with no side effect.
  - Minimum pop-to-pop spacing is 3 cycles.
- Reset mid-operation: pending, an in-flight fetch and the RESULT register are all discarded.

Optional Feature:
CSR_IRQ_EN
- Defined:
  - The irq port exists; irq = res_valid & IRQ_MASK, registered, so it asserts 1 cycle after res_valid sets.
  - It deasserts the cycle after the clearing read or after a mask write of 0.
- Undefined:
  - No irq port; CTRL bit31 reads 0 and writes to it are ignored.

Decomposition:
- Package csr_bank_pkg:
  - address offset constants;
  - CTRL/STATUS field positions;
  - result FSM state typedef {R_IDLE, R_FETCH, R_HOLD};
  - DROP_CNT_W=8.
- One sub-module, csr_result_fetch: the result FSM, RESULT register and res_valid.
- Flops reuse d_ff_async_en.

Test Plan:
- DATA_0=0x1234, DATA_1=0xABCD, CTRL=0x0000_0503 (START=1, OP=1, ID=5), fifo_in_full=0 -> one-cycle fifo_in_w_en next cycle, wdata={0xABCD,0x1234,0x05,2'b01}.
- fifo_in_full=1, START, then a 2nd START, hold full 10 cycles, release -> single push after release, STATUS.pending=1 while full, drop_cnt=1; DROP_CLR write -> drop_cnt=0.
- FIFO_OUT presents 0x1ABCDEF -> r_en 1 cycle, RESULT=0x01ABCDEF with res_valid=1; RESULT read clears res_valid; second entry pops only after that read.
- Read 0x0C, write 0x04, access 0x40 -> pslverr=1, prdata=0, no register change.
- Assert rst_n=0 while pending=1 and in R_FETCH -> all outputs 0 asynchronously, no push after release.
- CSR_IRQ_EN: IRQ_MASK=1, result arrives -> irq=1 one cycle after res_valid; RESULT read -> irq=0 next cycle.

Source files
------------

// File: rtl/csr_bank_pkg.sv
// csr_bank_pkg: shared constants and types for the csr_bank_apb CSR bank.
//   - APB byte-address offsets of every register
//   - CTRL / STATUS field positions
//   - result-fetch FSM state type
//   - drop counter width
package csr_bank_pkg;

    // Register byte offsets
    localparam int unsigned ADDR_CTRL      = 32'h00;
    localparam int unsigned ADDR_STATUS    = 32'h04;
    localparam int unsigned ADDR_RESULT    = 32'h08;
    localparam int unsigned ADDR_DROP_CLR  = 32'h0C;
    localparam int unsigned ADDR_DATA_BASE = 32'h10;

    // CTRL fields
    localparam int unsigned CTRL_START_BIT    = 0;
    localparam int unsigned CTRL_OP_LSB       = 1;
    localparam int unsigned CTRL_ID_LSB       = 8;
    localparam int unsigned CTRL_IRQ_MASK_BIT = 31;

    // STATUS fields
    localparam int unsigned STAT_FULL_BIT      = 0;
    localparam int unsigned STAT_EMPTY_BIT     = 1;
    localparam int unsigned STAT_PENDING_BIT   = 2;
    localparam int unsigned STAT_RES_VALID_BIT = 3;
    localparam int unsigned STAT_DROP_LSB      = 8;

    localparam int unsigned DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_HOLD  = 2'd2
    } r_state_e;

endpackage

// File: rtl/csr_result_fetch.sv
// csr_result_fetch: pulls one entry from FIFO_OUT into a sticky RESULT
// register and holds it until software reads it.
//   fifo_out_empty / fifo_out_r_en / fifo_out_rdata : FIFO_OUT read side
//                                                     (data valid 1 cycle after r_en)
//   res_clr   : clearing RESULT read completing this cycle
//   result    : RESULT register
//   res_valid : RESULT holds an unread value
module csr_result_fetch
    import csr_bank_pkg::*;
#(
    parameter int unsigned FIFO_OUT_WIDTH = 25
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fifo_out_empty,
    output logic                      fifo_out_r_en,
    input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_rdata,
    input  logic                      res_clr,
    output logic [FIFO_OUT_WIDTH-1:0] result,
    output logic                      res_valid
);

    r_state_e                  state_q, state_d;
    logic [1:0]                state_raw_q;
    logic [FIFO_OUT_WIDTH-1:0] result_q, result_d;
    logic                      res_valid_q, res_valid_d;

    assign state_q = r_state_e'(state_raw_q);

    always_comb begin
        state_d       = state_q;
        result_d      = result_q;
        res_valid_d   = res_valid_q;
        fifo_out_r_en = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (!fifo_out_empty && !res_valid_q) begin
                    fifo_out_r_en = 1'b1;
                    state_d       = R_FETCH;
                end
            end
            R_FETCH: begin
                // FIFO data is valid the cycle after the pop strobe
                result_d    = fifo_out_rdata;
                res_valid_d = 1'b1;
                state_d     = R_HOLD;
            end
            R_HOLD: begin
                if (res_clr) begin
                    res_valid_d = 1'b0;
                    state_d     = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    d_ff_async_en #(.WIDTH(2)) u_state_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (state_d),
        .q     (state_raw_q)
    );

    d_ff_async_en #(.WIDTH(FIFO_OUT_WIDTH)) u_result_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (result_d),
        .q     (result_q)
    );

    d_ff_async_en #(.WIDTH(1)) u_res_valid_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (res_valid_d),
        .q     (res_valid_q)
    );

    assign result    = result_q;
    assign res_valid = res_valid_q;

endmodule

// File: rtl/d_ff_async_en.sv
// d_ff_async_en: WIDTH-bit register with enable and asynchronous active-low
// reset to zero.
//   clk, rst_n : clock, async active-low reset
//   en         : load enable
//   d / q      : next value / registered value
module d_ff_async_en #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/csr_bank_apb.sv
// csr_bank_apb: zero-wait-state APB CSR bank for an ALU command/result path.
//   APB     : psel, penable, pwrite, paddr, pwdata, prdata, pready (tied 1), pslverr
//   FIFO_IN : fifo_in_full, fifo_in_w_en, fifo_in_wdata (command word
//             {DATA_{N-1}, ..., DATA_0, ID, OP})
//   FIFO_OUT: fifo_out_empty, fifo_out_r_en, fifo_out_rdata
//   irq     : result interrupt, present only when CSR_IRQ_EN is defined
// Build option: `define CSR_IRQ_EN adds CTRL.IRQ_MASK (bit31) and the irq port.
module csr_bank_apb
    import csr_bank_pkg::*;
#(
    parameter int unsigned APB_BUS_SIZE   = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_SIZE      = 16,
    parameter int unsigned NUM_OPERANDS   = 2,
    parameter int unsigned ID_SIZE        = 8,
    parameter int unsigned OPERATION_SIZE = 2,
    parameter int unsigned FIFO_OUT_WIDTH = 25,
    parameter int unsigned FIFO_IN_WIDTH  = NUM_OPERANDS * DATA_SIZE + ID_SIZE + OPERATION_SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDR_WIDTH-1:0]     paddr,
    input  logic [APB_BUS_SIZE-1:0]   pwdata,
    output logic [APB_BUS_SIZE-1:0]   prdata,
    output logic                      pready,
    output logic                      pslverr,
    input  logic                      fifo_in_full,
    output logic                      fifo_in_w_en,
    output logic [FIFO_IN_WIDTH-1:0]  fifo_in_wdata,
    input  logic                      fifo_out_empty,
    output logic                      fifo_out_r_en,
    input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_rdata
`ifdef CSR_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int unsigned CMD_LSB = ID_SIZE + OPERATION_SIZE;

    logic                      access, err, wr_ok, rd_ok;
    logic                      hit_ctrl, hit_status, hit_result, hit_drop, mapped;
    logic [NUM_OPERANDS-1:0]   hit_data;
    logic                      ctrl_we, start, start_ok, drop;
    logic [OPERATION_SIZE-1:0] op_q, op_d;
    logic [ID_SIZE-1:0]        id_q, id_d;
    logic [APB_BUS_SIZE-1:0]   data_q [NUM_OPERANDS];
    logic [FIFO_IN_WIDTH-1:0]  slot_q, slot_d;
    logic                      pending_q, pending_d;
    logic [DROP_CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic [FIFO_OUT_WIDTH-1:0] result;
    logic                      res_valid, res_clr;

    assign pready = 1'b1;
    assign access = psel & penable;

    // Address decode and error classification
    always_comb begin
        hit_ctrl   = (paddr == ADDR_WIDTH'(ADDR_CTRL));
        hit_status = (paddr == ADDR_WIDTH'(ADDR_STATUS));
        hit_result = (paddr == ADDR_WIDTH'(ADDR_RESULT));
        hit_drop   = (paddr == ADDR_WIDTH'(ADDR_DROP_CLR));
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            hit_data[i] = (paddr == ADDR_WIDTH'(ADDR_DATA_BASE + 4 * i));
        end
        mapped = hit_ctrl | hit_status | hit_result | hit_drop | (|hit_data);
        err    = access & (!mapped | (pwrite & (hit_status | hit_result)) |
                           (!pwrite & hit_drop));
        wr_ok  = access & pwrite & !err;
        rd_ok  = access & !pwrite & !err;
    end

    assign pslverr = err;
    assign res_clr = rd_ok & hit_result;

    // Command path: a START snapshots operands (pre-write values) plus the OP/ID
    // being written; a START while a command is still pending is dropped.
    always_comb begin
        ctrl_we  = wr_ok & hit_ctrl;
        start    = ctrl_we & pwdata[CTRL_START_BIT];
        start_ok = start & !pending_q;
        drop     = start & pending_q;
        op_d     = pwdata[CTRL_OP_LSB +: OPERATION_SIZE];
        id_d     = pwdata[CTRL_ID_LSB +: ID_SIZE];

        slot_d = '0;
        slot_d[OPERATION_SIZE-1:0]       = op_d;
        slot_d[OPERATION_SIZE +: ID_SIZE] = id_d;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            slot_d[CMD_LSB + i * DATA_SIZE +: DATA_SIZE] = data_q[i][DATA_SIZE-1:0];
        end

        fifo_in_w_en = pending_q & !fifo_in_full;

        pending_d = pending_q;
        if (start_ok) begin
            pending_d = 1'b1;
        end else if (fifo_in_w_en) begin
            pending_d = 1'b0;
        end

        drop_cnt_d = drop_cnt_q;
        if (wr_ok && hit_drop) begin
            drop_cnt_d = '0;
        end else if (drop && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    assign fifo_in_wdata = slot_q;

    d_ff_async_en #(.WIDTH(OPERATION_SIZE)) u_op_ff (
        .clk (clk), .rst_n (rst_n), .en (ctrl_we), .d (op_d), .q (op_q)
    );
    d_ff_async_en #(.WIDTH(ID_SIZE)) u_id_ff (
        .clk (clk), .rst_n (rst_n), .en (ctrl_we), .d (id_d), .q (id_q)
    );
    d_ff_async_en #(.WIDTH(FIFO_IN_WIDTH)) u_slot_ff (
        .clk (clk), .rst_n (rst_n), .en (start_ok), .d (slot_d), .q (slot_q)
    );
    d_ff_async_en #(.WIDTH(1)) u_pending_ff (
        .clk (clk), .rst_n (rst_n), .en (1'b1), .d (pending_d), .q (pending_q)
    );
    d_ff_async_en #(.WIDTH(DROP_CNT_W)) u_drop_cnt_ff (
        .clk (clk), .rst_n (rst_n), .en (1'b1), .d (drop_cnt_d), .q (drop_cnt_q)
    );

    for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_data
        d_ff_async_en #(.WIDTH(APB_BUS_SIZE)) u_data_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wr_ok & hit_data[g]),
            .d     (pwdata),
            .q     (data_q[g])
        );
    end

`ifdef CSR_IRQ_EN
    logic irq_mask_q, irq_q, irq_d;

    assign irq_d = res_valid & irq_mask_q;
    assign irq   = irq_q;

    d_ff_async_en #(.WIDTH(1)) u_irq_mask_ff (
        .clk (clk), .rst_n (rst_n), .en (ctrl_we),
        .d (pwdata[CTRL_IRQ_MASK_BIT]), .q (irq_mask_q)
    );
    d_ff_async_en #(.WIDTH(1)) u_irq_ff (
        .clk (clk), .rst_n (rst_n), .en (1'b1), .d (irq_d), .q (irq_q)
    );
`endif

    // Read mux; error accesses and idle bus return 0
    always_comb begin
        prdata = '0;
        if (access && !err) begin
            if (hit_ctrl) begin
                prdata[CTRL_OP_LSB +: OPERATION_SIZE] = op_q;
                prdata[CTRL_ID_LSB +: ID_SIZE]        = id_q;
`ifdef CSR_IRQ_EN
                prdata[CTRL_IRQ_MASK_BIT]             = irq_mask_q;
`endif
            end
            if (hit_status) begin
                prdata[STAT_FULL_BIT]                  = fifo_in_full;
                prdata[STAT_EMPTY_BIT]                 = fifo_out_empty;
                prdata[STAT_PENDING_BIT]               = pending_q;
                prdata[STAT_RES_VALID_BIT]             = res_valid;
                prdata[STAT_DROP_LSB +: DROP_CNT_W]    = drop_cnt_q;
            end
            if (hit_result) begin
                prdata = APB_BUS_SIZE'(result);
            end
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (hit_data[i]) begin
                    prdata = data_q[i];
                end
            end
        end
    end

    csr_result_fetch #(
        .FIFO_OUT_WIDTH (FIFO_OUT_WIDTH)
    ) u_result_fetch (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_out_empty (fifo_out_empty),
        .fifo_out_r_en  (fifo_out_r_en),
        .fifo_out_rdata (fifo_out_rdata),
        .res_clr        (res_clr),
        .result         (result),
        .res_valid      (res_valid)
    );

endmodule

// File: tb/tb_csr_bank_apb.sv
// tb_csr_bank_apb: directed self-checking bench for csr_bank_apb (default
// parameters). Build with `define CSR_IRQ_EN to exercise the irq path.
module tb_csr_bank_apb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic        fifo_in_full, fifo_in_w_en;
    logic [41:0] fifo_in_wdata;
    logic        fifo_out_empty, fifo_out_r_en;
    logic [24:0] fifo_out_rdata;
`ifdef CSR_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;
    int push_cnt = 0;
    int pop_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_in_w_en) push_cnt <= push_cnt + 1;
        if (fifo_out_r_en) pop_cnt <= pop_cnt + 1;
    end

    csr_bank_apb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .paddr          (paddr),
        .pwdata         (pwdata),
        .prdata         (prdata),
        .pready         (pready),
        .pslverr        (pslverr),
        .fifo_in_full   (fifo_in_full),
        .fifo_in_w_en   (fifo_in_w_en),
        .fifo_in_wdata  (fifo_in_wdata),
        .fifo_out_empty (fifo_out_empty),
        .fifo_out_r_en  (fifo_out_r_en),
        .fifo_out_rdata (fifo_out_rdata)
`ifdef CSR_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One zero-wait APB transfer; prdata/pslverr sampled mid access phase,
    // commit happens at the following rising edge.
    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rd = prdata;
        er = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp,
                          input logic exp_err);
        logic [31:0] d;
        logic        e;
        apb(1'b0, a, 32'h0, d, e);
        check({tag, "_rdata"}, 64'(d), 64'(exp));
        check({tag, "_err"}, 64'(e), 64'(exp_err));
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] a, input logic [31:0] wd,
                          input logic exp_err);
        logic [31:0] d;
        logic        e;
        apb(1'b1, a, wd, d, e);
        check({tag, "_err"}, 64'(e), 64'(exp_err));
    endtask

    logic [41:0] exp_w;
    int          p0;

    initial begin
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        fifo_in_full = 1'b0; fifo_out_empty = 1'b1; fifo_out_rdata = '0;
        #1;
        check("rst_w_en", 64'(fifo_in_w_en), 64'h0);
        check("rst_r_en", 64'(fifo_out_r_en), 64'h0);
        check("rst_prdata", 64'(prdata), 64'h0);
        check("rst_pslverr", 64'(pslverr), 64'h0);
        check("rst_wdata", 64'(fifo_in_wdata), 64'h0);
        check("pready", 64'(pready), 64'h1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        rd_chk("rst_ctrl", 8'h00, 32'h0, 1'b0);
        rd_chk("rst_status", 8'h04, 32'h2, 1'b0);
        rd_chk("rst_result", 8'h08, 32'h0, 1'b0);

        // Basic command push
        wr_chk("wr_d0", 8'h10, 32'h1234, 1'b0);
        wr_chk("wr_d1", 8'h14, 32'hABCD, 1'b0);
        p0 = push_cnt;
        wr_chk("wr_ctrl_start", 8'h00, 32'h0000_0503, 1'b0);
        exp_w = {16'hABCD, 16'h1234, 8'h05, 2'b01};
        check("push1_w_en", 64'(fifo_in_w_en), 64'h1);
        check("push1_wdata", 64'(fifo_in_wdata), 64'(exp_w));
        @(posedge clk); #1;
        check("push1_w_en_drop", 64'(fifo_in_w_en), 64'h0);
        check("push1_count", 64'(push_cnt), 64'(p0 + 1));
        rd_chk("push1_status", 8'h04, 32'h2, 1'b0);
        rd_chk("push1_ctrl", 8'h00, 32'h0000_0502, 1'b0);

        // Full FIFO_IN: second START is dropped, single push on release
        fifo_in_full = 1'b1;
        p0 = push_cnt;
        wr_chk("full_start1", 8'h00, 32'h0000_0001, 1'b0);
        wr_chk("full_start2", 8'h00, 32'h0000_0703, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("full_no_w_en", 64'(fifo_in_w_en), 64'h0);
        check("full_no_push", 64'(push_cnt), 64'(p0));
        rd_chk("full_status", 8'h04, 32'h0000_0107, 1'b0);
        rd_chk("full_ctrl", 8'h00, 32'h0000_0702, 1'b0);
        @(negedge clk) fifo_in_full = 1'b0;
        #1;
        exp_w = {16'hABCD, 16'h1234, 8'h00, 2'b00};
        check("rel_w_en", 64'(fifo_in_w_en), 64'h1);
        check("rel_wdata", 64'(fifo_in_wdata), 64'(exp_w));
        @(posedge clk); #1;
        check("rel_w_en_drop", 64'(fifo_in_w_en), 64'h0);
        check("rel_push_count", 64'(push_cnt), 64'(p0 + 1));
        wr_chk("drop_clr", 8'h0C, 32'h0, 1'b0);
        rd_chk("drop_clr_status", 8'h04, 32'h2, 1'b0);

        // Result fetch with a second entry waiting behind it
        p0 = pop_cnt;
        @(negedge clk);
        fifo_out_rdata = 25'h1ABCDEF;
        fifo_out_empty = 1'b0;
        #1;
        check("pop1_r_en", 64'(fifo_out_r_en), 64'h1);
        @(posedge clk); #1;
        check("fetch_r_en", 64'(fifo_out_r_en), 64'h0);
        @(posedge clk); #1;
        fifo_out_rdata = 25'h0000055;
        repeat (3) @(posedge clk);
        #1;
        check("hold_r_en", 64'(fifo_out_r_en), 64'h0);
        check("hold_pop_count", 64'(pop_cnt), 64'(p0 + 1));
        rd_chk("hold_status", 8'h04, 32'h8, 1'b0);
        rd_chk("result1", 8'h08, 32'h01AB_CDEF, 1'b0);
        check("pop2_r_en", 64'(fifo_out_r_en), 64'h1);
        @(posedge clk); #1;
        fifo_out_empty = 1'b1;
        @(posedge clk); #1;
        rd_chk("result2", 8'h08, 32'h0000_0055, 1'b0);
        check("pop2_count", 64'(pop_cnt), 64'(p0 + 2));
        rd_chk("result2_status", 8'h04, 32'h2, 1'b0);

        // Error responses
        rd_chk("err_rd_dropclr", 8'h0C, 32'h0, 1'b1);
        wr_chk("err_wr_status", 8'h04, 32'hFFFF_FFFF, 1'b1);
        wr_chk("err_wr_result", 8'h08, 32'hFFFF_FFFF, 1'b1);
        wr_chk("err_wr_unmapped", 8'h40, 32'hDEAD_BEEF, 1'b1);
        rd_chk("err_rd_unmapped", 8'h40, 32'h0, 1'b1);
        rd_chk("err_rd_data2", 8'h18, 32'h0, 1'b1);
        rd_chk("err_keep_d0", 8'h10, 32'h1234, 1'b0);
        rd_chk("err_keep_status", 8'h04, 32'h2, 1'b0);
        rd_chk("err_keep_result", 8'h08, 32'h0000_0055, 1'b0);

        // Reset while a command is pending and a fetch is in flight
        fifo_in_full = 1'b1;
        wr_chk("rst_mid_start", 8'h00, 32'h0000_0001, 1'b0);
        @(negedge clk);
        fifo_out_rdata = 25'h0000077;
        fifo_out_empty = 1'b0;
        @(posedge clk); #1;
        fifo_out_empty = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_w_en", 64'(fifo_in_w_en), 64'h0);
        check("rst_mid_r_en", 64'(fifo_out_r_en), 64'h0);
        check("rst_mid_prdata", 64'(prdata), 64'h0);
        check("rst_mid_pslverr", 64'(pslverr), 64'h0);
        fifo_in_full = 1'b0;
        #1;
        check("rst_mid_w_en_free", 64'(fifo_in_w_en), 64'h0);
        @(negedge clk) rst_n = 1'b1;
        p0 = push_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_no_push", 64'(push_cnt), 64'(p0));
        rd_chk("rst_mid_status", 8'h04, 32'h2, 1'b0);
        rd_chk("rst_mid_result", 8'h08, 32'h0, 1'b0);
        rd_chk("rst_mid_d0", 8'h10, 32'h0, 1'b0);

`ifdef CSR_IRQ_EN
        wr_chk("irq_mask_wr", 8'h00, 32'h8000_0000, 1'b0);
        rd_chk("irq_mask_rd", 8'h00, 32'h8000_0000, 1'b0);
        check("irq_idle", 64'(irq), 64'h0);
        @(negedge clk);
        fifo_out_rdata = 25'h0000003;
        fifo_out_empty = 1'b0;
        @(posedge clk); #1;
        fifo_out_empty = 1'b1;
        @(posedge clk); #1;
        check("irq_at_valid", 64'(irq), 64'h0);
        @(posedge clk); #1;
        check("irq_set", 64'(irq), 64'h1);
        rd_chk("irq_result", 8'h08, 32'h3, 1'b0);
        check("irq_after_read_edge", 64'(irq), 64'h1);
        @(posedge clk); #1;
        check("irq_clear", 64'(irq), 64'h0);
`else
        wr_chk("mask_ignored_wr", 8'h00, 32'h8000_0000, 1'b0);
        rd_chk("mask_ignored_rd", 8'h00, 32'h0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
